// File: rtl/tag_rename_table_if.sv
// Bundle of request and response signals for tag_rename_table.
//   master : drives rename, lookup, broadcast and flush requests; receives lookup results
//   slave  : the table itself
// Request signals:  ren_en/ren_reg/ren_tag, rd_en/rd_a/rd_b, bc_en/bc_tag/bc_data, flush
// Response signals: rd_valid, rd_rdy_a/b, rd_tag_a/b, rd_data_a/b, pend_cnt
interface tag_rename_table_if #(
   parameter int unsigned REG_W  = 4,
   parameter int unsigned TAG_W  = 8,
   parameter int unsigned DATA_W = 128
);
   logic              ren_en;
   logic [REG_W-1:0]  ren_reg;
   logic [TAG_W-1:0]  ren_tag;
   logic              rd_en;
   logic [REG_W-1:0]  rd_a;
   logic [REG_W-1:0]  rd_b;
   logic              bc_en;
   logic [TAG_W-1:0]  bc_tag;
   logic [DATA_W-1:0] bc_data;
   logic              flush;
   logic              rd_valid;
   logic              rd_rdy_a;
   logic              rd_rdy_b;
   logic [TAG_W-1:0]  rd_tag_a;
   logic [TAG_W-1:0]  rd_tag_b;
   logic [DATA_W-1:0] rd_data_a;
   logic [DATA_W-1:0] rd_data_b;
   logic [REG_W:0]    pend_cnt;

   modport master (
      output ren_en, ren_reg, ren_tag, rd_en, rd_a, rd_b, bc_en, bc_tag, bc_data, flush,
      input  rd_valid, rd_rdy_a, rd_rdy_b, rd_tag_a, rd_tag_b, rd_data_a, rd_data_b, pend_cnt
   );

   modport slave (
      input  ren_en, ren_reg, ren_tag, rd_en, rd_a, rd_b, bc_en, bc_tag, bc_data, flush,
      output rd_valid, rd_rdy_a, rd_rdy_b, rd_tag_a, rd_tag_b, rd_data_a, rd_data_b, pend_cnt
   );
endinterface

// File: rtl/tag_rename_table.sv
// Register rename table: each architectural register holds a pending flag, the tag of its
// outstanding producer and the last broadcast data value.
//   clk  : clock, all state on rising edge
//   rst  : asynchronous active-low reset
//   bus  : tag_rename_table_if slave modport (rename, two-source lookup, result broadcast,
//          flush, registered lookup results and registered pending count)
module tag_rename_table #(
   parameter int unsigned NREGS  = 16,
   parameter int unsigned REG_W  = 4,
   parameter int unsigned TAG_W  = 8,
   parameter int unsigned DATA_W = 128
) (
   input logic               clk,
   input logic               rst,
   tag_rename_table_if.slave bus
);

   logic [NREGS-1:0]  pend_q, pend_d;
   logic [TAG_W-1:0]  tag_q  [NREGS];
   logic [TAG_W-1:0]  tag_d  [NREGS];
   logic [DATA_W-1:0] data_q [NREGS];
   logic [DATA_W-1:0] data_d [NREGS];
   logic [NREGS-1:0]  bc_hit;
   logic [NREGS-1:0]  ren_hit;
   logic [REG_W:0]    cnt_d, cnt_q;

   logic              valid_d, valid_q;
   logic              rdy_a_d, rdy_a_q, rdy_b_d, rdy_b_q;
   logic [TAG_W-1:0]  tag_a_d, tag_a_q, tag_b_d, tag_b_q;
   logic [DATA_W-1:0] data_a_d, data_a_q, data_b_d, data_b_q;

   // Per-entry broadcast match and rename select; rename is suppressed during flush.
   always_comb begin
      bc_hit  = '0;
      ren_hit = '0;
      for (int i = 0; i < NREGS; i++) begin
         bc_hit[i]  = bus.bc_en && pend_q[i] && (tag_q[i] == bus.bc_tag);
         ren_hit[i] = bus.ren_en && !bus.flush && (bus.ren_reg == REG_W'(i));
      end
   end

   // Next table state. Rename beats a same-cycle broadcast on the same entry.
   always_comb begin
      pend_d = pend_q;
      cnt_d  = '0;
      for (int i = 0; i < NREGS; i++) begin
         tag_d[i]  = tag_q[i];
         data_d[i] = data_q[i];
         if (ren_hit[i]) begin
            pend_d[i] = 1'b1;
            tag_d[i]  = bus.ren_tag;
         end else if (bc_hit[i]) begin
            pend_d[i] = 1'b0;
            data_d[i] = bus.bc_data;
         end
         if (bus.flush) begin
            pend_d[i] = 1'b0;
         end
         cnt_d = cnt_d + (REG_W + 1)'(pend_d[i]);
      end
   end

   // Lookup on pre-update state, with same-cycle broadcast bypass.
   always_comb begin
      valid_d  = bus.rd_en;
      rdy_a_d  = 1'b0;
      rdy_b_d  = 1'b0;
      tag_a_d  = '0;
      tag_b_d  = '0;
      data_a_d = '0;
      data_b_d = '0;
      if (bus.rd_en) begin
         if (!pend_q[bus.rd_a]) begin
            rdy_a_d  = 1'b1;
            data_a_d = data_q[bus.rd_a];
         end else if (bc_hit[bus.rd_a]) begin
            rdy_a_d  = 1'b1;
            data_a_d = bus.bc_data;
         end else begin
            tag_a_d  = tag_q[bus.rd_a];
         end
         if (!pend_q[bus.rd_b]) begin
            rdy_b_d  = 1'b1;
            data_b_d = data_q[bus.rd_b];
         end else if (bc_hit[bus.rd_b]) begin
            rdy_b_d  = 1'b1;
            data_b_d = bus.bc_data;
         end else begin
            tag_b_d  = tag_q[bus.rd_b];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pend_q   <= '0;
         cnt_q    <= '0;
         valid_q  <= 1'b0;
         rdy_a_q  <= 1'b0;
         rdy_b_q  <= 1'b0;
         tag_a_q  <= '0;
         tag_b_q  <= '0;
         data_a_q <= '0;
         data_b_q <= '0;
         for (int i = 0; i < NREGS; i++) begin
            tag_q[i]  <= '0;
            data_q[i] <= '0;
         end
      end else begin
         pend_q   <= pend_d;
         cnt_q    <= cnt_d;
         valid_q  <= valid_d;
         rdy_a_q  <= rdy_a_d;
         rdy_b_q  <= rdy_b_d;
         tag_a_q  <= tag_a_d;
         tag_b_q  <= tag_b_d;
         data_a_q <= data_a_d;
         data_b_q <= data_b_d;
         for (int i = 0; i < NREGS; i++) begin
            tag_q[i]  <= tag_d[i];
            data_q[i] <= data_d[i];
         end
      end
   end

   assign bus.rd_valid  = valid_q;
   assign bus.rd_rdy_a  = rdy_a_q;
   assign bus.rd_rdy_b  = rdy_b_q;
   assign bus.rd_tag_a  = tag_a_q;
   assign bus.rd_tag_b  = tag_b_q;
   assign bus.rd_data_a = data_a_q;
   assign bus.rd_data_b = data_b_q;
   assign bus.pend_cnt  = cnt_q;

endmodule

// File: tb/tb_tag_rename_table.sv
// Directed, table-driven bench for tag_rename_table: each record is applied for one clock and
// the registered outputs are compared one time unit after the rising edge.
module tb_tag_rename_table;

   logic clk;
   logic rst;

   int checks = 0;
   int errors = 0;

   tag_rename_table_if #(.REG_W(4), .TAG_W(8), .DATA_W(128)) bus ();

   tag_rename_table #(.NREGS(16), .REG_W(4), .TAG_W(8), .DATA_W(128)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic         ren_en;
      logic [3:0]   ren_reg;
      logic [7:0]   ren_tag;
      logic         rd_en;
      logic [3:0]   rd_a;
      logic [3:0]   rd_b;
      logic         bc_en;
      logic [7:0]   bc_tag;
      logic [127:0] bc_data;
      logic         flush;
      logic         e_valid;
      logic         e_rdy_a;
      logic         e_rdy_b;
      logic [7:0]   e_tag_a;
      logic [7:0]   e_tag_b;
      logic [127:0] e_data_a;
      logic [127:0] e_data_b;
      logic [4:0]   e_cnt;
   } vec_t;

   localparam int NVEC = 21;
   vec_t vecs [NVEC];

   function automatic vec_t mk(
      input logic ren_en, input logic [3:0] ren_reg, input logic [7:0] ren_tag,
      input logic rd_en, input logic [3:0] rd_a, input logic [3:0] rd_b,
      input logic bc_en, input logic [7:0] bc_tag, input logic [127:0] bc_data,
      input logic flush,
      input logic e_valid, input logic e_rdy_a, input logic e_rdy_b,
      input logic [7:0] e_tag_a, input logic [7:0] e_tag_b,
      input logic [127:0] e_data_a, input logic [127:0] e_data_b, input logic [4:0] e_cnt);
      vec_t v;
      v.ren_en = ren_en;   v.ren_reg = ren_reg;   v.ren_tag = ren_tag;
      v.rd_en = rd_en;     v.rd_a = rd_a;         v.rd_b = rd_b;
      v.bc_en = bc_en;     v.bc_tag = bc_tag;     v.bc_data = bc_data;
      v.flush = flush;
      v.e_valid = e_valid; v.e_rdy_a = e_rdy_a;   v.e_rdy_b = e_rdy_b;
      v.e_tag_a = e_tag_a; v.e_tag_b = e_tag_b;
      v.e_data_a = e_data_a; v.e_data_b = e_data_b; v.e_cnt = e_cnt;
      return v;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic check_outs(input string pfx, input vec_t v);
      chk({pfx, " rd_valid"},  128'(bus.rd_valid),  128'(v.e_valid));
      chk({pfx, " rd_rdy_a"},  128'(bus.rd_rdy_a),  128'(v.e_rdy_a));
      chk({pfx, " rd_rdy_b"},  128'(bus.rd_rdy_b),  128'(v.e_rdy_b));
      chk({pfx, " rd_tag_a"},  128'(bus.rd_tag_a),  128'(v.e_tag_a));
      chk({pfx, " rd_tag_b"},  128'(bus.rd_tag_b),  128'(v.e_tag_b));
      chk({pfx, " rd_data_a"}, bus.rd_data_a,       v.e_data_a);
      chk({pfx, " rd_data_b"}, bus.rd_data_b,       v.e_data_b);
      chk({pfx, " pend_cnt"},  128'(bus.pend_cnt),  128'(v.e_cnt));
   endtask

   task automatic drive(input vec_t v);
      bus.ren_en  = v.ren_en;
      bus.ren_reg = v.ren_reg;
      bus.ren_tag = v.ren_tag;
      bus.rd_en   = v.rd_en;
      bus.rd_a    = v.rd_a;
      bus.rd_b    = v.rd_b;
      bus.bc_en   = v.bc_en;
      bus.bc_tag  = v.bc_tag;
      bus.bc_data = v.bc_data;
      bus.flush   = v.flush;
   endtask

   // Called at a falling edge; returns at the next falling edge.
   task automatic apply(input string pfx, input vec_t v);
      drive(v);
      @(posedge clk);
      #1;
      check_outs(pfx, v);
      @(negedge clk);
   endtask

   vec_t zero_v;

   initial begin
      //            ren      reg tag     rd a   b   bc tag    data     fl | v  ra rb ta     tb     da      db     cnt
      vecs[0]  = mk(0, 0,  8'h00, 1, 3,  5,  0, 8'h00, 0,       0, 1, 1, 1, 8'h00, 8'h00, 0,      0,     0);
      vecs[1]  = mk(1, 3,  8'h21, 0, 0,  0,  0, 8'h00, 0,       0, 0, 0, 0, 8'h00, 8'h00, 0,      0,     1);
      vecs[2]  = mk(0, 0,  8'h00, 1, 3,  3,  0, 8'h00, 0,       0, 1, 0, 0, 8'h21, 8'h21, 0,      0,     1);
      vecs[3]  = mk(0, 0,  8'h00, 1, 3,  4,  1, 8'h21, 'hAB,    0, 1, 1, 1, 8'h00, 8'h00, 'hAB,   0,     0);
      vecs[4]  = mk(0, 0,  8'h00, 1, 3,  3,  0, 8'h00, 0,       0, 1, 1, 1, 8'h00, 8'h00, 'hAB,   'hAB,  0);
      vecs[5]  = mk(1, 7,  8'h10, 0, 0,  0,  0, 8'h00, 0,       0, 0, 0, 0, 8'h00, 8'h00, 0,      0,     1);
      vecs[6]  = mk(1, 7,  8'h11, 1, 7,  0,  1, 8'h10, 'h55,    0, 1, 1, 1, 8'h00, 8'h00, 'h55,   0,     1);
      vecs[7]  = mk(0, 0,  8'h00, 1, 7,  7,  0, 8'h00, 0,       0, 1, 0, 0, 8'h11, 8'h11, 0,      0,     1);
      vecs[8]  = mk(0, 0,  8'h00, 0, 0,  0,  0, 8'h00, 0,       1, 0, 0, 0, 8'h00, 8'h00, 0,      0,     0);
      vecs[9]  = mk(1, 2,  8'h05, 1, 2,  7,  0, 8'h00, 0,       0, 1, 1, 1, 8'h00, 8'h00, 0,      0,     1);
      vecs[10] = mk(0, 0,  8'h00, 1, 2,  2,  0, 8'h00, 0,       0, 1, 0, 0, 8'h05, 8'h05, 0,      0,     1);
      vecs[11] = mk(0, 0,  8'h00, 0, 0,  0,  1, 8'h05, 'h22,    0, 0, 0, 0, 8'h00, 8'h00, 0,      0,     0);
      vecs[12] = mk(1, 1,  8'h00, 0, 0,  0,  0, 8'h00, 0,       0, 0, 0, 0, 8'h00, 8'h00, 0,      0,     1);
      vecs[13] = mk(0, 0,  8'h00, 1, 1,  0,  0, 8'h00, 0,       0, 1, 0, 1, 8'h00, 8'h00, 0,      0,     1);
      vecs[14] = mk(0, 0,  8'h00, 1, 1,  0,  1, 8'h00, 'h11,    0, 1, 1, 1, 8'h00, 8'h00, 'h11,   0,     0);
      vecs[15] = mk(1, 1,  8'h31, 0, 0,  0,  0, 8'h00, 0,       0, 0, 0, 0, 8'h00, 8'h00, 0,      0,     1);
      vecs[16] = mk(1, 2,  8'h32, 0, 0,  0,  0, 8'h00, 0,       0, 0, 0, 0, 8'h00, 8'h00, 0,      0,     2);
      vecs[17] = mk(1, 15, 8'h3F, 0, 0,  0,  0, 8'h00, 0,       0, 0, 0, 0, 8'h00, 8'h00, 0,      0,     3);
      vecs[18] = mk(1, 4,  8'h44, 1, 2,  1,  1, 8'h32, 'h99,    1, 1, 1, 0, 8'h00, 8'h31, 'h99,   0,     0);
      vecs[19] = mk(0, 0,  8'h00, 1, 1,  15, 0, 8'h00, 0,       0, 1, 1, 1, 8'h00, 8'h00, 'h11,   0,     0);
      vecs[20] = mk(0, 0,  8'h00, 1, 2,  4,  0, 8'h00, 0,       0, 1, 1, 1, 8'h00, 8'h00, 'h99,   0,     0);

      zero_v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      rst = 1'b0;
      drive(zero_v);
      #12;
      check_outs("reset", zero_v);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < NVEC; i++) begin
         apply($sformatf("v%0d", i), vecs[i]);
      end

      // Reset asserted mid-cycle with three renames pending and a lookup in flight.
      apply("pre_rst0", mk(1, 5, 8'h51, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      apply("pre_rst1", mk(1, 6, 8'h61, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2));
      apply("pre_rst2", mk(1, 8, 8'h81, 1, 5, 6, 0, 0, 0, 0, 1, 0, 0, 8'h51, 8'h61, 0, 0, 3));
      drive(mk(0, 0, 0, 1, 5, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(posedge clk);
      #1;
      check_outs("in_flight", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 8'h51, 8'h81, 0, 0, 3));
      #2;
      rst = 1'b0;
      #1;
      check_outs("async_rst", zero_v);
      @(posedge clk);
      #1;
      check_outs("held_rst", zero_v);
      @(negedge clk);
      rst = 1'b1;
      apply("post_rst0", mk(0, 0, 0, 1, 5, 8, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0));
      apply("post_rst1", mk(0, 0, 0, 1, 2, 6, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/tag_rename_table.md
TAG_RENAME_TABLE -- requirements
Module: tag_rename_table

Interface
REQ-001 Parameter NREGS, default 16: number of architectural registers; power of two, 2 to 64.
REQ-002 Parameter REG_W, default 4: register index width, equal to log2(NREGS).
REQ-003 Parameter TAG_W, default 8: producer tag width.
REQ-004 Parameter DATA_W, default 128: register data width.
REQ-005 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-006 Port rst, input, 1: asynchronous, active-low reset.
REQ-007 Port ren_en, input, 1: rename request; destination ren_reg gets new producer tag ren_tag.
REQ-008 Port ren_reg, input, REG_W: destination register index.
REQ-009 Port ren_tag, input, TAG_W: new producer tag.
REQ-010 Port rd_en, input, 1: source-lookup request.
REQ-011 Port rd_a, input, REG_W: first source register index.
REQ-012 Port rd_b, input, REG_W: second source register index.
REQ-013 Port bc_en, input, 1: result broadcast valid.
REQ-014 Port bc_tag, input, TAG_W: broadcast tag.
REQ-015 Port bc_data, input, DATA_W: broadcast data.
REQ-016 Port flush, input, 1: discard all outstanding renames.
REQ-017 Port rd_valid, output, 1: lookup result valid.
REQ-018 Ports rd_rdy_a and rd_rdy_b, output, 1 each: operand ready; the data field is meaningful, not the tag.
REQ-019 Ports rd_tag_a and rd_tag_b, output, TAG_W each: pending producer tag; 0 when the operand is ready.
REQ-020 Ports rd_data_a and rd_data_b, output, DATA_W each: operand value; 0 when the operand is not ready.
REQ-021 Port pend_cnt, output, REG_W+1: number of entries with pending=1.

Function
REQ-022 Each entry SHALL hold pending (1 bit), tag (TAG_W) and data (DATA_W).
REQ-023 Rename SHALL, when ren_en=1 and flush=0, set entry ren_reg to pending=1 and tag=ren_tag at the next edge; its data is unchanged.
REQ-024 Broadcast SHALL, when bc_en=1, write bc_data into every entry whose pending=1 and tag==bc_tag, and clear pending in those entries.
REQ-025 When the same entry is both renamed and matched by a broadcast in one cycle, rename SHALL win: pending=1, tag=ren_tag, data unchanged.
REQ-026 Lookup SHALL have 1-cycle latency: rd_en sampled at edge N gives rd_valid=1 and results held from edge N until edge N+1; with rd_en=0, rd_valid=0 and the result outputs are 0.
REQ-027 Lookup results SHALL reflect the table state before any same-cycle rename, so a source equal to ren_reg returns the old mapping.
REQ-028 Lookup SHALL bypass a same-cycle broadcast: a pending entry whose tag==bc_tag with bc_en=1 returns rdy=1 and data=bc_data.
REQ-029 rd_a==rd_b SHALL return identical A and B results.
REQ-030 Flush SHALL clear pending in all entries at the next edge, with data retained; a rename in the flush cycle is ignored and a broadcast in the flush cycle still writes data.
REQ-031 A lookup in the flush cycle SHALL return pre-flush state, with broadcast bypass applied.
REQ-032 pend_cnt SHALL be a registered count updated every edge to the post-update number of pending entries; range 0..NREGS.
REQ-033 Tag 0 is a legal tag value; the ready/pending distinction SHALL be carried only by pending and rdy, never by the tag value.

Reset
REQ-034 While rst=0, all entries SHALL be pending=0, tag=0, data=0, and rd_valid, rd_rdy_a/b, rd_tag_a/b, rd_data_a/b and pend_cnt SHALL all be 0, asynchronously.
REQ-035 Reset asserted mid-operation SHALL discard all renames and in-flight lookups; the first edge after rst returns to 1 operates on the reset state.

Verification
REQ-036 After reset, rd_en with a=3, b=5 -> rd_valid=1, both rdy=1, data=0, pend_cnt=0.
REQ-037 Rename r3 to tag 0x21, then look up a=3 -> rdy_a=0, tag_a=0x21; then broadcast 0x21 with data 0xAB plus a same-cycle lookup of a=3 -> rdy_a=1, data_a=0xAB, and pend_cnt goes 1 then 0.
REQ-038 Rename r7 to 0x10, then rename r7 to 0x11 with a same-cycle broadcast of 0x10 -> r7 pending with tag 0x11, data unchanged.
REQ-039 Same-cycle rename of r2 to 0x05 and lookup a=2 -> old ready value returned; the next lookup returns tag 0x05.
REQ-040 Rename r1, r2 and r15, then flush together with a rename of r4 -> pend_cnt=0, r4 not pending, r1, r2 and r15 return their prior data.
REQ-041 Assert rst=0 mid-cycle with 3 entries pending and a lookup in flight -> outputs go to 0 immediately; after release, a lookup of any register returns rdy=1, data=0.
